// File: rtl/cacheline_adaptor_pkg.sv
// rtl/cacheline_adaptor_pkg.sv - shared types and sizes for the line-to-burst adaptor
package cacheline_adaptor_pkg;
  localparam int S_LINE  = 256;
  localparam int S_BURST = 64;
  localparam int BEATS   = 4;
  localparam int BEAT_W  = 2;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
endpackage

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - serialises 256-bit line requests into four 64-bit memory bursts
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               line_read,
  input  logic               line_write,
  input  logic [31:0]        line_address,
  input  logic [S_LINE-1:0]  line_wdata,
  output logic [S_LINE-1:0]  line_rdata,
  output logic               line_resp,
  output logic [31:0]        burst_address,
  output logic               burst_read,
  output logic               burst_write,
  output logic [S_BURST-1:0] burst_wdata,
  input  logic [S_BURST-1:0] burst_rdata,
  input  logic               burst_resp
);
  state_t              state;
  logic [BEAT_W-1:0]   cnt;
  logic [BEAT_W-1:0]   cnt_nx;
  logic [S_LINE-1:0]   wbuf;
  logic                last_beat;

  assign cnt_nx    = cnt + 2'd1;
  assign last_beat = (cnt == BEAT_W'(BEATS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      wbuf          <= '0;
      line_rdata    <= '0;
      line_resp     <= 1'b0;
      burst_address <= '0;
      burst_read    <= 1'b0;
      burst_write   <= 1'b0;
      burst_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A write takes priority when both requests arrive together.
          if (line_write) begin
            burst_address <= {line_address[31:5], 5'b0};
            wbuf          <= line_wdata;
            burst_wdata   <= line_wdata[S_BURST-1:0];
            cnt           <= '0;
            burst_write   <= 1'b1;
            state         <= WR;
          end else if (line_read) begin
            burst_address <= {line_address[31:5], 5'b0};
            cnt           <= '0;
            burst_read    <= 1'b1;
            state         <= RD;
          end
        end
        RD: begin
          if (burst_resp) begin
            line_rdata[{cnt, 6'd0} +: S_BURST] <= burst_rdata;
            cnt <= cnt_nx;
            if (last_beat) begin
              burst_read <= 1'b0;
              line_resp  <= 1'b1;
              state      <= DONE;
            end
          end
        end
        WR: begin
          if (burst_resp) begin
            cnt <= cnt_nx;
            if (last_beat) begin
              burst_write <= 1'b0;
              burst_wdata <= '0;
              line_resp   <= 1'b1;
              state       <= DONE;
            end else begin
              burst_wdata <= wbuf[{cnt_nx, 6'd0} +: S_BURST];
            end
          end
        end
        DONE: begin
          // Requests are deliberately not sampled here so a held request is not reissued.
          line_resp <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          line_resp <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - scoreboard bench for cacheline_adaptor
module tb_cacheline_adaptor;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         line_read, line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata, line_rdata;
  logic         line_resp;
  logic [31:0]  burst_address;
  logic         burst_read, burst_write;
  logic [63:0]  burst_wdata, burst_rdata;
  logic         burst_resp;

  int compared = 0;
  int mismatched = 0;

  logic [255:0] exp_line_q[$];
  logic [63:0]  exp_beat_q[$];

  cacheline_adaptor dut (
    .clk(clk), .reset_n(reset_n),
    .line_read(line_read), .line_write(line_write),
    .line_address(line_address), .line_wdata(line_wdata),
    .line_rdata(line_rdata), .line_resp(line_resp),
    .burst_address(burst_address), .burst_read(burst_read),
    .burst_write(burst_write), .burst_wdata(burst_wdata),
    .burst_rdata(burst_rdata), .burst_resp(burst_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full read transaction; a gap of gap_len idle cycles is inserted before beat gap_beat.
  task automatic do_read(input string name, input logic [31:0] a, input logic [255:0] line,
                         input int gap_beat, input int gap_len);
    int ticks;
    logic [255:0] exp;
    line_read = 1'b1;
    line_address = a;
    exp_line_q.push_back(line);
    tick();
    ticks = 1;
    compared++;
    if (burst_read !== 1'b1 || burst_write !== 1'b0 || burst_address !== {a[31:5], 5'b0}) begin
      mismatched++;
      $display("FAIL %s_issue: rd=%b wr=%b addr=%h, required rd=1 wr=0 addr=%h",
               name, burst_read, burst_write, burst_address, {a[31:5], 5'b0});
    end
    for (int i = 0; i < 4; i++) begin
      if (i == gap_beat) begin
        for (int g = 0; g < gap_len; g++) begin
          burst_resp = 1'b0;
          tick();
          ticks++;
        end
      end
      compared++;
      if (burst_read !== 1'b1 || line_resp !== 1'b0) begin
        mismatched++;
        $display("FAIL %s_beat%0d: rd=%b resp=%b, required rd=1 resp=0", name, i, burst_read, line_resp);
      end
      burst_resp = 1'b1;
      burst_rdata = line[64*i +: 64];
      tick();
      ticks++;
    end
    burst_resp = 1'b0;
    burst_rdata = '0;
    for (int w = 0; w < 10 && line_resp !== 1'b1; w++) begin
      tick();
      ticks++;
    end
    exp = exp_line_q.pop_front();
    compared++;
    if (line_resp !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_resp_timeout: line_resp=%b, required 1 within 10 cycles", name, line_resp);
    end else begin
      if (line_rdata !== exp) begin
        mismatched++;
        $display("FAIL %s_rdata: got %h, required %h", name, line_rdata, exp);
      end
      compared++;
      if (ticks != 5 + gap_len || burst_read !== 1'b0) begin
        mismatched++;
        $display("FAIL %s_latency: edges=%0d rd=%b, required edges=%0d rd=0", name, ticks, burst_read, 5 + gap_len);
      end
    end
    line_read = 1'b0;
    tick();
    compared++;
    if (line_resp !== 1'b0 || burst_read !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_resp_pulse: resp=%b rd=%b, required 0 0", name, line_resp, burst_read);
    end
  endtask

  // Full write transaction; hold_read leaves line_read asserted through DONE.
  task automatic do_write(input string name, input logic [31:0] a, input logic [255:0] line,
                          input logic also_read, input logic hold_read);
    int ticks;
    logic [63:0] exp;
    line_write = 1'b1;
    line_read = also_read;
    line_address = a;
    line_wdata = line;
    for (int i = 0; i < 4; i++) exp_beat_q.push_back(line[64*i +: 64]);
    tick();
    ticks = 1;
    // Latched data must not follow later input changes.
    line_wdata = ~line;
    line_address = ~a;
    compared++;
    if (burst_write !== 1'b1 || burst_address !== {a[31:5], 5'b0}) begin
      mismatched++;
      $display("FAIL %s_issue: wr=%b addr=%h, required wr=1 addr=%h", name, burst_write, burst_address, {a[31:5], 5'b0});
    end
    for (int i = 0; i < 4; i++) begin
      exp = exp_beat_q.pop_front();
      compared++;
      if (burst_wdata !== exp || burst_read !== 1'b0 || line_resp !== 1'b0) begin
        mismatched++;
        $display("FAIL %s_wdata%0d: got %h rd=%b resp=%b, required %h rd=0 resp=0",
                 name, i, burst_wdata, burst_read, line_resp, exp);
      end
      burst_resp = 1'b1;
      tick();
      ticks++;
    end
    burst_resp = 1'b0;
    for (int w = 0; w < 10 && line_resp !== 1'b1; w++) begin
      tick();
      ticks++;
    end
    compared++;
    if (line_resp !== 1'b1 || ticks != 5 || burst_write !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_resp: resp=%b edges=%0d wr=%b, required resp=1 edges=5 wr=0", name, line_resp, ticks, burst_write);
    end
    line_write = 1'b0;
    line_read = hold_read;
    tick();
    compared++;
    if (line_resp !== 1'b0 || burst_read !== 1'b0 || burst_write !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_after_done: resp=%b rd=%b wr=%b, required 0 0 0", name, line_resp, burst_read, burst_write);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    line_read = 1'b0;
    line_write = 1'b0;
    line_address = '0;
    line_wdata = '0;
    burst_rdata = '0;
    burst_resp = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    compared++;
    if (line_resp !== 1'b0 || burst_read !== 1'b0 || burst_write !== 1'b0 ||
        burst_address !== 32'h0 || burst_wdata !== 64'h0 || line_rdata !== 256'h0) begin
      mismatched++;
      $display("FAIL reset_state: resp=%b rd=%b wr=%b addr=%h wdata=%h rdata=%h, required all zero",
               line_resp, burst_read, burst_write, burst_address, burst_wdata, line_rdata);
    end
  endtask

  task automatic test_read();
    do_read("read", 32'h0000_1234, {64'h3, 64'h2, 64'h1, 64'h0}, -1, 0);
    do_read("read2", 32'hCAFE_F00F,
            {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'hA5A5_5A5A_A5A5_5A5A, 64'hFFFF_0000_FFFF_0000}, -1, 0);
  endtask

  task automatic test_write();
    do_write("write", 32'h8000_0040,
             {{8{8'hDD}}, {8{8'hCC}}, {8{8'hBB}}, {8{8'hAA}}}, 1'b0, 1'b0);
    compared++;
    if (line_rdata !== {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'hA5A5_5A5A_A5A5_5A5A, 64'hFFFF_0000_FFFF_0000}) begin
      mismatched++;
      $display("FAIL rdata_hold_after_write: got %h", line_rdata);
    end
  endtask

  task automatic test_gap();
    do_read("gap", 32'h0000_1234, {64'h3, 64'h2, 64'h1, 64'h0}, 2, 2);
  endtask

  task automatic test_both_and_hold();
    do_write("both", 32'h0000_2000,
             {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
             1'b1, 1'b1);
    // line_read still high: it is only accepted now that the FSM is back in IDLE.
    do_read("held_read", 32'h0000_3000,
            {64'hDEAD_0003, 64'hDEAD_0002, 64'hDEAD_0001, 64'hDEAD_0000}, -1, 0);
  endtask

  task automatic test_reset_mid_burst();
    line_read = 1'b1;
    line_address = 32'h0000_4444;
    tick();
    for (int i = 0; i < 2; i++) begin
      burst_resp = 1'b1;
      burst_rdata = 64'hBAD0_0000 + 64'(i);
      tick();
    end
    reset_n = 1'b0;
    #1;
    compared++;
    if (line_resp !== 1'b0 || burst_read !== 1'b0 || burst_write !== 1'b0 ||
        burst_address !== 32'h0 || burst_wdata !== 64'h0 || line_rdata !== 256'h0) begin
      mismatched++;
      $display("FAIL async_reset: resp=%b rd=%b wr=%b addr=%h wdata=%h rdata=%h, required all zero",
               line_resp, burst_read, burst_write, burst_address, burst_wdata, line_rdata);
    end
    burst_resp = 1'b0;
    line_read = 1'b0;
    #1;
    reset_n = 1'b1;
    tick();
    compared++;
    if (burst_read !== 1'b0 || line_resp !== 1'b0) begin
      mismatched++;
      $display("FAIL post_reset_idle: rd=%b resp=%b, required 0 0", burst_read, line_resp);
    end
    do_read("fresh", 32'h0000_4444,
            {64'h7777_0003, 64'h7777_0002, 64'h7777_0001, 64'h7777_0000}, -1, 0);
  endtask

  task automatic test_spurious_resp();
    burst_resp = 1'b1;
    burst_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    tick();
    burst_resp = 1'b0;
    compared++;
    if (burst_read !== 1'b0 || burst_write !== 1'b0 || line_resp !== 1'b0) begin
      mismatched++;
      $display("FAIL spurious_idle: rd=%b wr=%b resp=%b, required 0 0 0", burst_read, burst_write, line_resp);
    end
    do_read("after_spurious", 32'h0000_5020,
            {64'h9999_0003, 64'h9999_0002, 64'h9999_0001, 64'h9999_0000}, 1, 1);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_gap();
    test_both_and_hold();
    test_reset_mid_burst();
    test_spurious_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
